// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
// Holds the FSM state encodings (2'b11 is illegal and recovers to IDLE),
// the default operand width and a counter-width helper.
package serial_adder_ctrl_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Bit counter must reach WIDTH-1 without wrapping.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between a client and serial_adder_ctrl.
//   start      : request, sampled only when the controller is IDLE or DONE
//   a, b       : operands, captured on the accepting edge
//   busy       : high while the add is in progress
//   done       : one-cycle pulse, sum/cout valid
//   sum, cout  : result, held until the next accepted start
// master = client side, slave = controller side.
interface serial_adder_ctrl_if
  import serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/fulladd_from_half.sv
// One-bit full adder built from two half adders and an OR on the carries.
//   x, y, cin : input bits
//   s_c       : x ^ y ^ cin (combinational)
//   co_c      : majority(x, y, cin) (combinational)
module fulladd_from_half (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s_c,
  output logic co_c
);

  logic s0;
  logic c0;
  logic c1;

  halfadd_dataflow u_ha0 (
    .x   (x),
    .y   (y),
    .s_c (s0),
    .c_c (c0)
  );

  halfadd_dataflow u_ha1 (
    .x   (s0),
    .y   (cin),
    .s_c (s_c),
    .c_c (c1)
  );

  // At most one half adder can generate a carry, so OR is the full carry.
  assign co_c = c0 | c1;

endmodule

// File: rtl/halfadd_dataflow.sv
// Dataflow half adder.
//   x, y : input bits
//   s_c  : x ^ y (combinational)
//   c_c  : x & y (combinational)
module halfadd_dataflow (
  input  logic x,
  input  logic y,
  output logic s_c,
  output logic c_c
);

  assign s_c = x ^ y;
  assign c_c = x & y;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one shared full-adder cell is stepped LSB
// first, one bit per clock, then the result is presented with a done pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of serial_adder_ctrl_if (start/a/b in,
//                busy/done/sum/cout out, all outputs registered)
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_adder_ctrl_if.slave   bus
);

  localparam int unsigned       CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state;
  state_e           state_nx;
  logic             busy_nx;
  logic             done_nx;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] sum_shift;
  logic [CNT_W-1:0] cnt;
  logic             carry;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;

  logic             accept;
  logic             last;
  logic             cell_s;
  logic             cell_co;

  // Start is only honoured between operations.
  assign accept = bus.start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last   = (state == ST_RUN) && (cnt == CNT_LAST);

  // Cell result enters from the MSB side so bit 0 ends at sum[0].
  assign sum_shift = {cell_s, sum_sr[WIDTH-1:1]};

  fulladd_from_half u_cell (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .cin  (carry),
    .s_c  (cell_s),
    .co_c (cell_co)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; the unused encoding falls back to IDLE.
  always_comb begin
    state_nx = ST_IDLE;
    case (state)
      ST_IDLE: state_nx = bus.start ? ST_RUN : ST_IDLE;
      ST_RUN:  state_nx = last ? ST_DONE : ST_RUN;
      ST_DONE: state_nx = bus.start ? ST_RUN : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Status decode from the next state so busy/done register in step with it.
  always_comb begin
    busy_nx = 1'b0;
    done_nx = 1'b0;
    case (state_nx)
      ST_RUN:  busy_nx = 1'b1;
      ST_DONE: done_nx = 1'b1;
      default: ;
    endcase
  end

  // Operand shift registers, bit counter and carry flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
    end else if (accept) begin
      a_sr   <= bus.a;
      b_sr   <= bus.b;
      cnt    <= '0;
      carry  <= 1'b0;
    end else if (state == ST_RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      sum_sr <= sum_shift;
      carry  <= cell_co;
      cnt    <= last ? '0 : cnt + CNT_W'(1);
    end
  end

  // Result and status registers; result only moves on the edge into DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_nx;
      done_q <= done_nx;
      if (last) begin
        sum_q  <= sum_shift;
        cout_q <= cell_co;
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: an 8-bit instance driven through
// a result scoreboard, plus a 2-bit instance for the narrow-width case.
module tb_serial_adder_ctrl;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_pass;
  int   done_cnt;
  logic [8:0] exp_q[$];

  serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_adder_ctrl_if #(.WIDTH(2)) bus2 ();

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  serial_adder_ctrl #(.WIDTH(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding add.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n) begin
      check_val("busy_done_excl", 32'(bus8.busy & bus8.done), 32'd0);
      if (bus8.done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check_val("spurious_done_qsize", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check_val("sum", 32'(bus8.sum), 32'(e[7:0]));
          check_val("cout", 32'(bus8.cout), 32'(e[8]));
        end
      end
    end
  end

  // Drive a request at a negedge and record the reference result.
  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    bus8.start = 1'b1;
    bus8.a     = a;
    bus8.b     = b;
    exp_q.push_back({1'b0, a} + {1'b0, b});
  endtask

  // Follow an accepted request through RUN to its done cycle.
  task automatic expect_run(input int glitch_at, output int done_at);
    @(posedge clk);
    #1 bus8.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_val("busy_in_run", 32'(bus8.busy), 32'd1);
      check_val("done_in_run", 32'(bus8.done), 32'd0);
      if (i == glitch_at) begin
        bus8.start = 1'b1;
        bus8.a     = 8'h11;
        bus8.b     = 8'h22;
      end else begin
        bus8.start = 1'b0;
      end
    end
    @(negedge clk);
    check_val("done_pulse", 32'(bus8.done), 32'd1);
    check_val("busy_at_done", 32'(bus8.busy), 32'd0);
    done_at = cyc;
  endtask

  initial begin
    int t1;
    int t2;
    int d0;
    n_checks   = 0;
    n_pass     = 0;
    done_cnt   = 0;
    rst_n      = 1'b0;
    bus8.start = 1'b0;
    bus8.a     = '0;
    bus8.b     = '0;
    bus2.start = 1'b0;
    bus2.a     = '0;
    bus2.b     = '0;

    repeat (3) @(negedge clk);
    check_val("rst_busy", 32'(bus8.busy), 32'd0);
    check_val("rst_done", 32'(bus8.done), 32'd0);
    check_val("rst_sum", 32'(bus8.sum), 32'd0);
    check_val("rst_cout", 32'(bus8.cout), 32'd0);
    check_val("rst_busy_w2", 32'(bus2.busy), 32'd0);
    check_val("rst_sum_w2", 32'(bus2.sum), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero operands.
    issue(8'h00, 8'h00);
    expect_run(-1, t1);
    @(negedge clk);

    // Overflow to carry-out, with a start pulse mid-run that must be ignored.
    d0 = done_cnt;
    issue(8'hFF, 8'h01);
    expect_run(3, t1);
    @(negedge clk);
    check_val("sum_held", 32'(bus8.sum), 32'h00);
    check_val("cout_held", 32'(bus8.cout), 32'd1);
    check_val("done_one_cycle", 32'(bus8.done), 32'd0);
    repeat (3) @(negedge clk);
    check_val("single_done_ignored_start", 32'(done_cnt - d0), 32'd1);

    issue(8'hA5, 8'h5A);
    expect_run(-1, t1);
    @(negedge clk);
    issue(8'h80, 8'h80);
    expect_run(-1, t1);
    @(negedge clk);

    // Back-to-back: start held through DONE.
    issue(8'hF0, 8'h22);
    expect_run(-1, t1);
    issue(8'h03, 8'h04);
    expect_run(-1, t2);
    check_val("b2b_gap", 32'(t2 - t1), 32'd9);
    @(negedge clk);

    for (int n = 0; n < 6; n++) begin
      issue(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      expect_run(-1, t1);
      @(negedge clk);
    end

    // Add 03+04 so sum is non-zero before the abort.
    issue(8'h03, 8'h04);
    expect_run(-1, t1);
    @(negedge clk);

    // Abort mid-run with reset: no done pulse, outputs cleared at once.
    bus8.start = 1'b1;
    bus8.a     = 8'h0F;
    bus8.b     = 8'h01;
    @(posedge clk);
    #1 bus8.start = 1'b0;
    repeat (4) @(negedge clk);
    check_val("busy_before_abort", 32'(bus8.busy), 32'd1);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check_val("abort_busy", 32'(bus8.busy), 32'd0);
    check_val("abort_done", 32'(bus8.done), 32'd0);
    check_val("abort_sum", 32'(bus8.sum), 32'd0);
    check_val("abort_cout", 32'(bus8.cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check_val("no_done_after_abort", 32'(done_cnt - d0), 32'd0);
    issue(8'h0F, 8'h01);
    expect_run(-1, t1);
    @(negedge clk);

    // 2-bit instance: 3 + 3 = 6.
    bus2.start = 1'b1;
    bus2.a     = 2'b11;
    bus2.b     = 2'b11;
    @(posedge clk);
    #1 bus2.start = 1'b0;
    @(negedge clk);
    check_val("w2_busy0", 32'(bus2.busy), 32'd1);
    @(negedge clk);
    check_val("w2_busy1", 32'(bus2.busy), 32'd1);
    check_val("w2_done_early", 32'(bus2.done), 32'd0);
    @(negedge clk);
    check_val("w2_done", 32'(bus2.done), 32'd1);
    check_val("w2_sum", 32'(bus2.sum), 32'd2);
    check_val("w2_cout", 32'(bus2.cout), 32'd1);
    @(negedge clk);
    check_val("w2_done_cleared", 32'(bus2.done), 32'd0);

    check_val("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
